// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Brief    : Multicycle MIPS HI/LO unit: mult/multu/div/divu with a fixed
//            busy window, plus mthi/mtlo writes.
// Revision : 1.0
// ============================================================================
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [2:0] c_op_mult  = 3'd1;
    localparam logic [2:0] c_op_multu = 3'd2;
    localparam logic [2:0] c_op_div   = 3'd3;
    localparam logic [2:0] c_op_divu  = 3'd4;
    localparam logic [2:0] c_op_mthi  = 3'd5;
    localparam logic [2:0] c_op_mtlo  = 3'd6;

    localparam logic [4:0] c_mult_cycles = 5'(MULT_CYCLES);
    localparam logic [4:0] c_div_cycles  = 5'(DIV_CYCLES);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [4:0]  r_cnt;
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_launch;
    logic        w_done;
    logic        w_wr_hi_mt;
    logic        w_wr_lo_mt;

    // ------------------------------------------------------------------
    // Next-state and command decode. Commands are only honoured in IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_launch     = 1'b0;
        w_done       = 1'b0;
        w_wr_hi_mt   = 1'b0;
        w_wr_lo_mt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (mdu_op == c_op_mult || mdu_op == c_op_multu ||
                        mdu_op == c_op_div  || mdu_op == c_op_divu) begin
                        w_launch     = 1'b1;
                        w_next_state = S_RUN;
                    end
                    w_wr_hi_mt = (mdu_op == c_op_mthi);
                    w_wr_lo_mt = (mdu_op == c_op_mtlo);
                end
            end
            S_RUN: begin
                if (r_cnt == 5'd1) begin
                    w_done       = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Result datapath, evaluated from the latched operands only.
    // ------------------------------------------------------------------
    logic        w_is_mult;
    logic        w_is_signed;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [63:0] w_prod;

    assign w_is_mult   = (r_op == c_op_mult) || (r_op == c_op_multu);
    assign w_is_signed = (r_op == c_op_mult) || (r_op == c_op_div);
    assign w_prod_s    = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
    assign w_prod_u    = {32'd0, r_a} * {32'd0, r_b};
    assign w_prod      = w_is_signed ? w_prod_s : w_prod_u;

    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_dvd_mag;
    logic [31:0] w_dvs_mag;
    logic [31:0] w_dvs_safe;
    logic [31:0] w_quo_mag;
    logic [31:0] w_rem_mag;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic        w_div_by_zero;

    // Signed divide runs on magnitudes; 0x80000000 / -1 wraps back to
    // 0x80000000 with zero remainder through the same path.
    assign w_a_neg       = w_is_signed && r_a[31];
    assign w_b_neg       = w_is_signed && r_b[31];
    assign w_dvd_mag     = w_a_neg ? (32'd0 - r_a) : r_a;
    assign w_dvs_mag     = w_b_neg ? (32'd0 - r_b) : r_b;
    assign w_div_by_zero = (r_b == 32'd0);
    assign w_dvs_safe    = w_div_by_zero ? 32'd1 : w_dvs_mag;
    assign w_quo_mag     = w_dvd_mag / w_dvs_safe;
    assign w_rem_mag     = w_dvd_mag % w_dvs_safe;
    assign w_quo         = (w_a_neg ^ w_b_neg) ? (32'd0 - w_quo_mag) : w_quo_mag;
    assign w_rem         = w_a_neg ? (32'd0 - w_rem_mag) : w_rem_mag;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= 5'd0;
            r_op  <= 3'd0;
            r_a   <= 32'd0;
            r_b   <= 32'd0;
            r_hi  <= 32'd0;
            r_lo  <= 32'd0;
        end else begin
            if (w_launch) begin
                r_op  <= mdu_op;
                r_a   <= A;
                r_b   <= B;
                r_cnt <= (mdu_op == c_op_mult || mdu_op == c_op_multu) ?
                         c_mult_cycles : c_div_cycles;
            end else if (r_state == S_RUN) begin
                r_cnt <= r_cnt - 5'd1;
            end

            if (w_done) begin
                if (w_is_mult) begin
                    r_hi <= w_prod[63:32];
                    r_lo <= w_prod[31:0];
                end else if (!w_div_by_zero) begin
                    r_hi <= w_rem;
                    r_lo <= w_quo;
                end
            end

            if (w_wr_hi_mt) begin
                r_hi <= A;
            end
            if (w_wr_lo_mt) begin
                r_lo <= A;
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit for the multicycle MIPS datapath.
- Sits beside the combinational ALU and shares the same A/B operand buses.
- Executes mult/multu/div/divu over a fixed number of cycles into the HI/LO registers, and services mthi/mtlo.
- Raises busy so the controller stalls any later HI/LO access until the result is committed.

Parameters:
- MULT_CYCLES, 5: busy cycles for mult/multu (legal range 1..31).
- DIV_CYCLES, 10: busy cycles for div/divu (legal range 1..31).

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- start  input  1  qualifies mdu_op for one cycle.
- mdu_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved.
- A  input  32  rs operand (dividend / multiplicand / mthi,mtlo source).
- B  input  32  rt operand (divisor / multiplier).
- busy  output  1  operation in flight.
- HI  output  32  HI register (upper product / remainder).
- LO  output  32  LO register (lower product / quotient).

Behaviour:
- Reset: busy=0, HI=0, LO=0, internal counter=0, latched operands cleared. Reset has priority over everything, including mid-operation; any in-flight result is discarded and never written.
- States: IDLE, RUN.
- IDLE -> RUN: on start=1 with mdu_op in 1..4. At that edge:
  - A, B and op are latched.
  - counter is loaded with MULT_CYCLES or DIV_CYCLES.
  - busy goes high from the next cycle.
- RUN: counter decrements each edge. busy=1 for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
- RUN -> IDLE: on the edge where counter reaches 1. At that same edge HI/LO take the result and busy drops. The result is visible in the first cycle with busy=0.
- Latency: start sampled at edge k; busy=1 during cycles k+1..k+N; new HI/LO valid from cycle k+N+1.
- HI/LO hold their old values throughout RUN. Operand changes on A/B during RUN have no effect.
- mthi (5) in IDLE: HI<=A at that edge, LO unchanged, busy stays 0.
- mtlo (6) in IDLE: LO<=A at that edge, HI unchanged, busy stays 0.
- Ignored commands:
  - start with mdu_op 0 or 7: no effect.
  - any start while busy=1 (including mthi/mtlo): dropped, no state change. The controller must stall.
- mult: signed 32x32 -> 64; {HI,LO} = $signed(A)*$signed(B).
- multu: unsigned 64-bit product.
- div: signed; LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
- div overflow case: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0x00000000.
- divu: unsigned quotient/remainder.
- Divide by zero (B==0, div or divu): busy still runs the full DIV_CYCLES; HI and LO are left unchanged at completion.
- The result is computed from the latched operands only. Implementation is free to compute it at start or iteratively, provided the visible timing above is exact.
- HI/LO are registered outputs; no combinational path from A/B/start to HI/LO/busy.

Test Plan:
- Reset, then mult A=0xFFFFFFFF B=0x00000002 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu A=0xFFFFFFFF B=0x00000002 -> after 5 busy cycles, HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (-7) B=2 -> busy 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7 B=2 -> LO=3, HI=1.
- Divide by zero: mthi A=0x12345678, mtlo A=0x9ABCDEF0 (each 1 cycle, busy stays 0); then div B=0 -> busy 10 cycles; HI/LO still 0x12345678/0x9ABCDEF0.
- During a running mult:
  - assert start with div A=100 B=3 -> ignored.
  - assert start with mthi A=0xDEADBEEF -> ignored.
  - Final HI/LO equal the original mult product; busy drops after exactly 5 cycles.
- Start div A=100 B=3, assert reset in busy cycle 4 -> next cycle busy=0, HI=0, LO=0. No later update occurs (check 10 further cycles).
